instr_mem: RTL and testbench

INSTR_MEM -- requirements
Module: instr_mem

---
 rtl/instr_mem_if.sv | 27 ++
 rtl/instr_mem.sv | 60 ++++++
 tb/tb_instr_mem.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_if.sv
// Bus bundle for the instruction memory: enables, byte address, write data and registered read data.
interface instr_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              ren;
  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;

  modport master (
    output ren,
    output wen,
    output addr,
    output data_i,
    input  data_o
  );

  modport slave (
    input  ren,
    input  wen,
    input  addr,
    input  data_i,
    output data_o
  );
endinterface

// File: rtl/instr_mem.sv
// Word-addressed instruction memory with registered read and write-through on simultaneous read/write.
// Define INSTR_MEM_RST_CLR_EN to make reset also clear every memory word.
module instr_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  instr_mem_if.slave  bus
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  logic [ADDR_W-3:0] word_idx;
  logic [1:0]        unused_byte_off;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  // Byte offset is dropped: misaligned addresses hit the containing word.
  assign word_idx        = bus.addr[ADDR_W-1:2];
  assign unused_byte_off = bus.addr[1:0];

`ifdef INSTR_MEM_RST_CLR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus.wen) begin
      mem_q[word_idx] <= bus.data_i;
    end
  end
`else
  // No reset on the array so it maps to block RAM; rst_n still blocks writes on edges taken in reset.
  always_ff @(posedge clk) begin
    if (rst_n && bus.wen) begin
      mem_q[word_idx] <= bus.data_i;
    end
  end
`endif

  always_comb begin
    data_d = data_q;
    if (bus.ren) begin
      data_d = bus.wen ? bus.data_i : mem_q[word_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign bus.data_o = data_q;

endmodule

// File: tb/tb_instr_mem.sv
// Directed bench for instr_mem: reset, write/read, aliasing, write-through, hold and async reset.
module tb_instr_mem;

  localparam int DW = 32;
  localparam int AW = 10;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  instr_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  instr_mem #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Apply one set of inputs across a rising edge, then settle 1 time unit past it.
  task automatic cycle(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ren    = r;
    bus.wen    = w;
    bus.addr   = a;
    bus.data_i = d;
    @(posedge clk);
    #1;
    $display("txn t=%0t rst_n=%0b ren=%0b wen=%0b addr=%0d data_i=%h data_o=%h",
             $time, rst_n, r, w, a, d, bus.data_o);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.data_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_async got=%h want=%h", bus.data_o, 32'h0);
    end
    cycle(1'b1, 1'b1, 10'd16, 32'h0000_0055);
    total++;
    if (bus.data_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_edge got=%h want=%h", bus.data_o, 32'h0);
    end
    rst_n = 1'b1;
`ifdef INSTR_MEM_RST_CLR_EN
    cycle(1'b1, 1'b0, 10'd0, 32'h0);
    total++;
    if (bus.data_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_clear_word0 got=%h want=%h", bus.data_o, 32'h0);
    end
`endif
  endtask

  task automatic test_write_read;
    cycle(1'b0, 1'b1, 10'd4, 32'h0000_0003);
    total++;
    if (bus.data_o !== 32'h0) begin
      bad++;
      $display("FAIL write_holds_data_o got=%h want=%h", bus.data_o, 32'h0);
    end
    cycle(1'b1, 1'b0, 10'd4, 32'h0);
    total++;
    if (bus.data_o !== 32'h0000_0003) begin
      bad++;
      $display("FAIL read_addr4 got=%h want=%h", bus.data_o, 32'h0000_0003);
    end
  endtask

  task automatic test_alias;
    logic [DW-1:0] exp12;
`ifdef INSTR_MEM_RST_CLR_EN
    exp12 = 32'h0;
`else
    // Without clearing reset, word 3 is undefined until written.
    cycle(1'b0, 1'b1, 10'd12, 32'h1234_5678);
    exp12 = 32'h1234_5678;
`endif
    cycle(1'b1, 1'b0, 10'd12, 32'h0);
    total++;
    if (bus.data_o !== exp12) begin
      bad++;
      $display("FAIL read_addr12 got=%h want=%h", bus.data_o, exp12);
    end
    cycle(1'b1, 1'b0, 10'd5, 32'h0);
    total++;
    if (bus.data_o !== 32'h0000_0003) begin
      bad++;
      $display("FAIL alias_addr5 got=%h want=%h", bus.data_o, 32'h0000_0003);
    end
    cycle(1'b1, 1'b0, 10'd7, 32'h0);
    total++;
    if (bus.data_o !== 32'h0000_0003) begin
      bad++;
      $display("FAIL alias_addr7 got=%h want=%h", bus.data_o, 32'h0000_0003);
    end
  endtask

  task automatic test_write_through;
    cycle(1'b1, 1'b1, 10'd8, 32'hDEAD_BEEF);
    total++;
    if (bus.data_o !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL write_through got=%h want=%h", bus.data_o, 32'hDEAD_BEEF);
    end
    cycle(1'b1, 1'b0, 10'd8, 32'h0);
    total++;
    if (bus.data_o !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL read_addr8 got=%h want=%h", bus.data_o, 32'hDEAD_BEEF);
    end
    // Misaligned write lands on word 2 and must not disturb data_o.
    cycle(1'b0, 1'b1, 10'd10, 32'hCAFE_F00D);
    total++;
    if (bus.data_o !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL misaligned_write_hold got=%h want=%h", bus.data_o, 32'hDEAD_BEEF);
    end
    cycle(1'b1, 1'b0, 10'd8, 32'h0);
    total++;
    if (bus.data_o !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL read_after_misaligned got=%h want=%h", bus.data_o, 32'hCAFE_F00D);
    end
  endtask

  task automatic test_hold;
    cycle(1'b0, 1'b0, 10'd4, 32'hFFFF_FFFF);
    total++;
    if (bus.data_o !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL idle_hold got=%h want=%h", bus.data_o, 32'hCAFE_F00D);
    end
    cycle(1'b1, 1'b0, 10'd4, 32'h0);
    total++;
    if (bus.data_o !== 32'h0000_0003) begin
      bad++;
      $display("FAIL idle_no_write got=%h want=%h", bus.data_o, 32'h0000_0003);
    end
  endtask

  task automatic test_back_to_back;
    cycle(1'b0, 1'b1, 10'd16, 32'hA5A5_0001);
    cycle(1'b1, 1'b0, 10'd16, 32'h0);
    total++;
    if (bus.data_o !== 32'hA5A5_0001) begin
      bad++;
      $display("FAIL b2b_read16 got=%h want=%h", bus.data_o, 32'hA5A5_0001);
    end
    cycle(1'b0, 1'b1, 10'd1020, 32'h5A5A_0FFC);
    cycle(1'b0, 1'b1, 10'd20, 32'h0000_0014);
    cycle(1'b1, 1'b0, 10'd1023, 32'h0);
    total++;
    if (bus.data_o !== 32'h5A5A_0FFC) begin
      bad++;
      $display("FAIL top_word_alias got=%h want=%h", bus.data_o, 32'h5A5A_0FFC);
    end
    cycle(1'b1, 1'b0, 10'd20, 32'h0);
    total++;
    if (bus.data_o !== 32'h0000_0014) begin
      bad++;
      $display("FAIL b2b_read20 got=%h want=%h", bus.data_o, 32'h0000_0014);
    end
    cycle(1'b1, 1'b0, 10'd16, 32'h0);
    total++;
    if (bus.data_o !== 32'hA5A5_0001) begin
      bad++;
      $display("FAIL b2b_reread16 got=%h want=%h", bus.data_o, 32'hA5A5_0001);
    end
  endtask

  task automatic test_async_reset;
    logic [DW-1:0] exp4;
    cycle(1'b1, 1'b0, 10'd4, 32'h0);
    total++;
    if (bus.data_o !== 32'h0000_0003) begin
      bad++;
      $display("FAIL pre_reset_read got=%h want=%h", bus.data_o, 32'h0000_0003);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.data_o !== 32'h0) begin
      bad++;
      $display("FAIL mid_cycle_reset got=%h want=%h", bus.data_o, 32'h0);
    end
    // Write attempted while in reset must be dropped.
    cycle(1'b1, 1'b1, 10'd4, 32'hBAD0_BAD0);
    total++;
    if (bus.data_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_blocks_access got=%h want=%h", bus.data_o, 32'h0);
    end
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 10'd4, 32'h0);
`ifdef INSTR_MEM_RST_CLR_EN
    exp4 = 32'h0;
`else
    exp4 = 32'h0000_0003;
`endif
    total++;
    if (bus.data_o !== exp4) begin
      bad++;
      $display("FAIL post_reset_addr4 got=%h want=%h", bus.data_o, exp4);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    bus.ren    = 1'b0;
    bus.wen    = 1'b0;
    bus.addr   = '0;
    bus.data_i = '0;
    test_reset();
    test_write_read();
    test_alias();
    test_write_through();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
